fb_stream_reader: RTL and testbench

//  Read-side client of the single-port-per-clock framebuffer RAM (1-cycle registered read latency).
//  On a start pulse it scans one full frame in raster order, issues rd_addr and absorbs the

---
 rtl/fb_pkg.sv | 29 ++
 rtl/fb_skid_fifo.sv | 100 ++++++++++
 rtl/fb_stream_reader.sv | 222 ++++++++++++++++++++++
 tb/tb_fb_stream_reader.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// -----------------------------------------------------------------------------
// fb_pkg
// Shared framebuffer constants and types for the framebuffer read path.
//   FB_*         default framebuffer geometry and widths
//   fbr_state_t  stream reader FSM states
//   fb_pix_t     buffered pixel with its frame/line position tags
// -----------------------------------------------------------------------------
package fb_pkg;

    localparam int FB_H_RES   = 320;
    localparam int FB_V_RES   = 240;
    localparam int FB_PIXELS  = FB_H_RES * FB_V_RES;
    localparam int FB_ADDR_W  = 17;
    localparam int FB_DATA_W  = 8;

    typedef enum logic [1:0] {
        FBR_IDLE  = 2'b00,
        FBR_RUN   = 2'b01,
        FBR_DRAIN = 2'b10
    } fbr_state_t;

    typedef struct packed {
        logic                 sof;
        logic                 eol;
        logic                 eof;
        logic [FB_DATA_W-1:0] pix;
    } fb_pix_t;

endpackage

// File: rtl/fb_skid_fifo.sv
// -----------------------------------------------------------------------------
// fb_skid_fifo
// Small fall-through FIFO that absorbs the framebuffer read latency.
// When empty, a push is visible on head/valid in the same cycle, and a
// simultaneous pop consumes it without it ever being stored.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   push        write push_data this cycle
//   push_data   entry to write
//   pop         consumer takes head this cycle (ignored when valid=0)
//   head        oldest entry (or the pushed entry when empty); zero when idle
//   valid       head holds a real entry
//   count       stored entries, used by the producer for credit checks
// -----------------------------------------------------------------------------
module fb_skid_fifo
    import fb_pkg::*;
#(
    parameter int  DEPTH   = 2,
    parameter type entry_t = fb_pix_t,
    parameter int  CNT_W   = $clog2(DEPTH + 1)
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  entry_t           push_data,
    input  logic             pop,
    output entry_t           head,
    output logic             valid,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int ENTRY_W = $bits(entry_t);

    entry_t           mem_r [DEPTH];
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [CNT_W-1:0] count_r;

    logic empty_s;
    logic full_s;
    logic bypass_s;
    logic write_s;
    logic read_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            ptr_inc = {PTR_W{1'b0}};
        end else begin
            ptr_inc = p + PTR_W'(1'b1);
        end
    endfunction

    // Occupancy decode, bypass detection and head selection.
    always_comb begin
        empty_s  = (count_r == {CNT_W{1'b0}});
        full_s   = (count_r == CNT_W'(DEPTH));
        // Empty + push + pop: the entry passes straight through, nothing stored.
        bypass_s = empty_s && push && pop;
        read_s   = pop && !empty_s;
        // Full writes are only taken when a slot frees in the same cycle.
        write_s  = push && !bypass_s && (!full_s || read_s);
        valid    = !empty_s || push;
        if (!empty_s) begin
            head = mem_r[rd_ptr_r];
        end else if (push) begin
            head = push_data;
        end else begin
            head = entry_t'({ENTRY_W{1'b0}});
        end
    end

    assign count = count_r;

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= entry_t'({ENTRY_W{1'b0}});
            end
        end else begin
            if (write_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= ptr_inc(wr_ptr_r);
            end
            if (read_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            if (write_s && !read_s) begin
                count_r <= count_r + CNT_W'(1'b1);
            end else if (read_s && !write_s) begin
                count_r <= count_r - CNT_W'(1'b1);
            end
        end
    end

endmodule

// File: rtl/fb_stream_reader.sv
// -----------------------------------------------------------------------------
// fb_stream_reader
// Scans one framebuffer frame in raster order and presents it as a
// valid/ready pixel stream with SOF/EOL/EOF tags. Reads are issued only
// when the FIFO can hold the result, so backpressure never loses a pixel.
// Build option:
//   FB_READER_CONTINUOUS_EN  defined: after the last address the scan wraps
//                            to address 0 and streams frames back-to-back
//                            until reset. Undefined: one frame per start.
// Ports:
//   clk        clock (framebuffer read clock is the same clock)
//   rst_n      asynchronous active-low reset
//   start      begin a frame; ignored while busy
//   rd_addr    framebuffer read address
//   rd_data    framebuffer read data, one cycle after rd_addr
//   out_valid  / out_ready / out_data   pixel stream handshake and data
//   out_sof    first pixel of frame
//   out_eol    last pixel of a line
//   out_eof    last pixel of frame
//   busy       frame in progress
//   done       one-cycle pulse after the EOF handshake
// -----------------------------------------------------------------------------
module fb_stream_reader
    import fb_pkg::*;
#(
    parameter int H_RES      = FB_H_RES,
    parameter int V_RES      = FB_V_RES,
    parameter int ADDR_W     = FB_ADDR_W,
    parameter int DATA_W     = FB_DATA_W,
    parameter int FIFO_DEPTH = 2
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sof,
    output logic              out_eol,
    output logic              out_eof,
    output logic              busy,
    output logic              done
);

    localparam int XW    = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int YW    = (V_RES > 1) ? $clog2(V_RES) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int OCC_W = CNT_W + 1;

    typedef struct packed {
        logic              sof;
        logic              eol;
        logic              eof;
        logic [DATA_W-1:0] pix;
    } pix_entry_t;

    fbr_state_t        state_r;
    fbr_state_t        state_nxt_s;
    logic [ADDR_W-1:0] addr_r;
    logic [XW-1:0]     x_r;
    logic [YW-1:0]     y_r;
    logic              inflight_r;
    logic              infl_sof_r;
    logic              infl_eol_r;
    logic              infl_eof_r;
    logic              busy_r;
    logic              done_r;

    logic              x_last_s;
    logic              y_last_s;
    logic [OCC_W-1:0]  occupancy_s;
    logic              issue_s;
    logic              last_issue_s;
    logic              pop_s;
    logic              eof_hs_s;
    logic [CNT_W-1:0]  fifo_count_s;
    logic              fifo_valid_s;
    pix_entry_t        push_entry_s;
    pix_entry_t        head_s;

    // Issue decision: credit covers both stored entries and the read in flight.
    always_comb begin
        x_last_s     = (x_r == XW'(H_RES - 1));
        y_last_s     = (y_r == YW'(V_RES - 1));
        occupancy_s  = {1'b0, fifo_count_s} + {{CNT_W{1'b0}}, inflight_r};
        issue_s      = (state_r == FBR_RUN) && (occupancy_s < OCC_W'(FIFO_DEPTH));
        last_issue_s = issue_s && x_last_s && y_last_s;
        pop_s        = fifo_valid_s && out_ready;
        eof_hs_s     = pop_s && head_s.eof;
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            FBR_IDLE: begin
                if (start) begin
                    state_nxt_s = FBR_RUN;
                end else begin
                    state_nxt_s = FBR_IDLE;
                end
            end
            FBR_RUN: begin
                if (last_issue_s) begin
`ifdef FB_READER_CONTINUOUS_EN
                    state_nxt_s = FBR_RUN;
`else
                    state_nxt_s = FBR_DRAIN;
`endif
                end else begin
                    state_nxt_s = FBR_RUN;
                end
            end
            FBR_DRAIN: begin
                // EOF is the final entry, so its handshake leaves the FIFO empty.
                if (eof_hs_s) begin
                    state_nxt_s = FBR_IDLE;
                end else begin
                    state_nxt_s = FBR_DRAIN;
                end
            end
            default: begin
                state_nxt_s = FBR_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= FBR_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Raster counters; rd_addr advances by one per issue and holds at the last pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_r <= {ADDR_W{1'b0}};
            x_r    <= {XW{1'b0}};
            y_r    <= {YW{1'b0}};
        end else if (state_r == FBR_IDLE) begin
            if (start) begin
                addr_r <= {ADDR_W{1'b0}};
                x_r    <= {XW{1'b0}};
                y_r    <= {YW{1'b0}};
            end
        end else if (issue_s) begin
            if (last_issue_s) begin
`ifdef FB_READER_CONTINUOUS_EN
                addr_r <= {ADDR_W{1'b0}};
                x_r    <= {XW{1'b0}};
                y_r    <= {YW{1'b0}};
`endif
            end else if (x_last_s) begin
                addr_r <= addr_r + ADDR_W'(1'b1);
                x_r    <= {XW{1'b0}};
                y_r    <= y_r + YW'(1'b1);
            end else begin
                addr_r <= addr_r + ADDR_W'(1'b1);
                x_r    <= x_r + XW'(1'b1);
            end
        end
    end

    // Tags travel alongside the read so they line up with rd_data next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_r <= 1'b0;
            infl_sof_r <= 1'b0;
            infl_eol_r <= 1'b0;
            infl_eof_r <= 1'b0;
        end else begin
            inflight_r <= issue_s;
            infl_sof_r <= issue_s && (addr_r == {ADDR_W{1'b0}});
            infl_eol_r <= issue_s && x_last_s;
            infl_eof_r <= last_issue_s;
        end
    end

    // Status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_nxt_s != FBR_IDLE);
            done_r <= eof_hs_s;
        end
    end

    assign push_entry_s = '{sof: infl_sof_r, eol: infl_eol_r, eof: infl_eof_r, pix: rd_data};

    fb_skid_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (pix_entry_t),
        .CNT_W   (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight_r),
        .push_data (push_entry_s),
        .pop       (pop_s),
        .head      (head_s),
        .valid     (fifo_valid_s),
        .count     (fifo_count_s)
    );

    // Stream outputs come from the fall-through FIFO head (zero while empty).
    assign rd_addr   = addr_r;
    assign out_valid = fifo_valid_s;
    assign out_data  = head_s.pix;
    assign out_sof   = head_s.sof;
    assign out_eol   = head_s.eol;
    assign out_eof   = head_s.eof;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: tb/tb_fb_stream_reader.sv
// -----------------------------------------------------------------------------
// tb_fb_stream_reader
// Directed bench for fb_stream_reader on a reduced 8x4 frame with a
// behavioural framebuffer (mem[i] = i[7:0], one-cycle read latency).
// Define FB_READER_CONTINUOUS_EN for the back-to-back frame scenario.
// -----------------------------------------------------------------------------
module tb_fb_stream_reader;
    import fb_pkg::*;

    localparam int H    = 8;
    localparam int V    = 4;
    localparam int NPIX = H * V;
    localparam int AW   = 5;
    localparam int DW   = 8;
    localparam int D    = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_sof;
    logic          out_eol;
    logic          out_eof;
    logic          busy;
    logic          done;

    int vectors     = 0;
    int miscompares = 0;
    int done_cnt    = 0;

    fb_stream_reader #(
        .H_RES      (H),
        .V_RES      (V),
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .FIFO_DEPTH (D)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sof   (out_sof),
        .out_eol   (out_eol),
        .out_eof   (out_eof),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Framebuffer model: registered read, content equals low address byte.
    always @(posedge clk) rd_data <= DW'(rd_addr);

    // Count done pulses.
    always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Consume stream beats until stop_beat, checking data, tags, hold and gaps.
    task automatic stream_check(input int mode, input int restart_beat, input int stop_beat,
                                output int nbeats, output int first_cyc);
        int          beat = 0;
        int          cyc  = 0;
        logic        held = 1'b0;
        logic [11:0] hv   = 12'h000;
        first_cyc = -1;
        while (beat < stop_beat && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (held) chk("hold_stable", {out_valid, out_sof, out_eol, out_eof, out_data}, hv);
            chk("busy_in_frame", busy, 1);
            chk("fifo_no_overflow", dut.u_fifo.push && (dut.u_fifo.count_r == D), 0);
            if (mode == 0) out_ready = 1'b1;
            else           out_ready = 1'($urandom_range(0, 1));
            if (mode == 0 && beat > 0) chk("no_gap", out_valid, 1);
            if (beat == restart_beat) start = 1'b1;
            if (out_valid && out_ready) begin
                if (beat == 0) first_cyc = cyc;
                chk("data", out_data, beat & 32'hFF);
                chk("sof", out_sof, beat == 0);
                chk("eol", out_eol, (beat % H) == H - 1);
                chk("eof", out_eof, beat == NPIX - 1);
                beat++;
                held = 1'b0;
            end else begin
                held = out_valid;
                hv   = {out_valid, out_sof, out_eol, out_eof, out_data};
            end
        end
        if (beat < stop_beat) chk("stream_timeout", beat, stop_beat);
        start  = 1'b0;
        nbeats = beat;
    endtask

    // After the EOF handshake: one done pulse, busy low, no further dones.
    task automatic check_done_tail(input int d0);
        @(negedge clk);
        chk("done_pulse", done, 1);
        chk("busy_after_eof", busy, 0);
        repeat (4) begin
            @(negedge clk);
            chk("done_single", done, 0);
            chk("busy_idle", busy, 0);
        end
        chk("done_count", done_cnt - d0, 1);
    endtask

    initial begin
        int nb;
        int fc;
        int d0;
        rst_n     = 1'b0;
        start     = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_tags", {out_sof, out_eol, out_eof}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst_n = 1'b1;
        @(negedge clk);

`ifndef FB_READER_CONTINUOUS_EN
        // 1: full-rate frame, latency start->addr0 (cycle1)->valid (cycle2)
        d0 = done_cnt;
        out_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t1_addr0", rd_addr, 0);
        chk("t1_valid_cycle1", out_valid, 0);
        chk("t1_busy", busy, 1);
        stream_check(0, -1, NPIX, nb, fc);
        chk("t1_first_beat_cycle2", fc, 1);
        chk("t1_beats", nb, NPIX);
        check_done_tail(d0);

        // 2: random backpressure
        d0 = done_cnt;
        start = 1'b1;
        stream_check(1, -1, NPIX, nb, fc);
        chk("t2_beats", nb, NPIX);
        check_done_tail(d0);

        // 3: stall 100 cycles after start: two reads buffered, rd_addr frozen at 2
        d0 = done_cnt;
        out_ready = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        chk("t3_fifo_count", dut.u_fifo.count_r, D);
        repeat (90) begin
            @(negedge clk);
            chk("t3_rd_addr_frozen", rd_addr, 2);
            chk("t3_head", {out_valid, out_sof, out_data}, {1'b1, 1'b1, 8'h00});
        end
        stream_check(0, -1, NPIX, nb, fc);
        chk("t3_resume_first", fc, 1);
        // start in the same cycle as done is accepted
        @(negedge clk);
        chk("t3_done_pulse", done, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t3_done_count", done_cnt - d0, 1);
        chk("t4_start_on_done_busy", busy, 1);
        chk("t4_start_on_done_addr", rd_addr, 0);

        // 4: start pulsed again at beat 10 is ignored
        d0 = done_cnt;
        stream_check(0, 10, NPIX, nb, fc);
        chk("t4_beats", nb, NPIX);
        check_done_tail(d0);

        // 5: asynchronous reset at beat 20, then a clean frame from address 0
        d0 = done_cnt;
        start = 1'b1;
        stream_check(0, -1, 20, nb, fc);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_outputs", {rd_addr, out_valid, out_data, out_sof, out_eol, out_eof, busy, done}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("t5_no_done", done, 0);
        end
        chk("t5_done_count", done_cnt - d0, 0);
        start = 1'b1;
        stream_check(0, -1, NPIX, nb, fc);
        chk("t5_restart_first", fc, 2);
        check_done_tail(d0);
`else
        // 6: continuous mode, three frames back-to-back from one start
        d0 = done_cnt;
        out_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int f = 0; f < 3; f++) begin
            stream_check(0, -1, NPIX, nb, fc);
            chk("t6_sof_follows_eof", fc, 1);
        end
        @(negedge clk);
        chk("t6_done_pulse", done, 1);
        chk("t6_busy_held", busy, 1);
        @(negedge clk);
        chk("t6_done_count", done_cnt - d0, 3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
